// File: rtl/parity_check_ser.sv
// Serial parity checker: tracks the XOR of incoming bits, either unbounded or
// restarting every FRAME_LEN bits, and presents it as a registered Moore flag.
//
// state | meaning
// EVEN  | even count of 1s seen so far (in this frame)
// ODD   | odd count of 1s seen so far (in this frame)
module parity_check_ser #(
    parameter bit ODD_SENSE = 1'b1,
    parameter int FRAME_LEN = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic data,
    output logic check
);

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } state_t;

    state_t state;
    state_t next_state;
    logic   frame_start;

    generate
        if (FRAME_LEN > 0) begin : g_frame
            localparam int CW = $clog2(FRAME_LEN) + 1;
            localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

            logic [CW-1:0] bit_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bit_cnt <= '0;
                end else if (bit_cnt == LAST) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            assign frame_start = (bit_cnt == '0);
        end else begin : g_free
            assign frame_start = 1'b0;
        end
    endgenerate

    // First bit of a frame discards the previous parity entirely.
    always_comb begin
        next_state = state;
        if (frame_start) begin
            next_state = data ? ODD : EVEN;
        end else if (data) begin
            next_state = (state == ODD) ? EVEN : ODD;
        end
    end

    // check is registered alongside state so it always equals the decode of state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EVEN;
            check <= ~ODD_SENSE;
        end else begin
            state <= next_state;
            check <= ODD_SENSE ? (next_state == ODD) : (next_state == EVEN);
        end
    end

endmodule

// File: tb/tb_parity_check_ser.sv
// Bench for parity_check_ser: three instances (running, inverted sense, framed N=4)
// share one stimulus stream and are checked against a bit-history reference model.
module tb_parity_check_ser;

    logic clk;
    logic rst_n;
    logic data;
    logic check_run;
    logic check_inv;
    logic check_frm;

    int checks   = 0;
    int failures = 0;

    // Every bit sampled since the last reset, oldest first.
    logic hist[$];

    parity_check_ser #(.ODD_SENSE(1'b1), .FRAME_LEN(0)) u_run (
        .clk(clk), .rst_n(rst_n), .data(data), .check(check_run)
    );
    parity_check_ser #(.ODD_SENSE(1'b0), .FRAME_LEN(0)) u_inv (
        .clk(clk), .rst_n(rst_n), .data(data), .check(check_inv)
    );
    parity_check_ser #(.ODD_SENSE(1'b1), .FRAME_LEN(4)) u_frm (
        .clk(clk), .rst_n(rst_n), .data(data), .check(check_frm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Parity of the bits belonging to the current frame (whole history if unframed).
    function automatic logic model_parity(input int frame_len);
        int   n;
        int   start;
        logic p;
        n = hist.size();
        p = 1'b0;
        if (frame_len == 0 || n == 0) start = 0;
        else start = ((n - 1) / frame_len) * frame_len;
        for (int i = start; i < n; i++) p ^= hist[i];
        return p;
    endfunction

    always @(posedge clk) begin
        if (rst_n) hist.push_back(data);
        #1;
        chk("model_run", check_run, model_parity(0));
        chk("model_inv", check_inv, ~model_parity(0));
        chk("model_frm", check_frm, model_parity(4));
    end

    task automatic step(input logic d);
        @(negedge clk);
        #2 data = d;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, toggles data while
    // held, then releases away from the edge.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        hist.delete();
        #1;
        chk("async_rst_run", check_run, 1'b0);
        chk("async_rst_inv", check_inv, 1'b1);
        chk("async_rst_frm", check_frm, 1'b0);
        repeat (2) begin
            @(negedge clk);
            #2 data = ~data;
            @(posedge clk);
        end
        #2 rst_n = 1'b1;
    endtask

    logic s2_in  [15] = '{0,0,1,0,1,1,1,0,0,1,1,0,1,0,1};
    logic s2_exp [15] = '{0,0,1,1,0,1,0,0,0,1,0,0,1,1,0};
    logic s5_in  [12] = '{1,1,1,0, 1,0,0,0, 0,0,0,0};
    logic s5_exp [12] = '{1,0,1,1, 1,1,1,1, 0,0,0,0};
    logic s6_in  [4]  = '{1,0,0,0};
    logic s6_exp [4]  = '{1,1,1,1};

    initial begin
        rst_n = 1'b0;
        data  = 1'b0;
        #12;
        chk("reset_run", check_run, 1'b0);
        chk("reset_inv", check_inv, 1'b1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Enter ODD, then reset asynchronously.
        step(1'b1);
        chk("pre_rst_odd", check_run, 1'b1);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            step(s2_in[i]);
            chk("run_seq", check_run, s2_exp[i]);
            chk("inv_seq", check_inv, ~s2_exp[i]);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0);
            chk("run_hold0", check_run, 1'b0);
        end

        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            chk("all_ones", check_run, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            chk("all_zeros", check_run, 1'b0);
        end

        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(s5_in[i]);
            chk("frame_seq", check_frm, s5_exp[i]);
        end

        do_reset();
        step(1'b1);
        step(1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(s6_in[i]);
            chk("frame_abort", check_frm, s6_exp[i]);
        end

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(49) == 0) do_reset();
            step(1'(($urandom() >> 3) & 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
